// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared sizes, types and helpers for the register scoreboard
//
// Purpose: register-file geometry and pending-counter width used by the
//          scoreboard, its interface and the per-register counter.
// Ports:   none (package).
package sb_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // True when a tracked destination feeds either operand of the issuing instruction.
    function automatic logic src_match(input reg_idx_t dest, input reg_idx_t src1,
                                       input reg_idx_t src2, input logic two_src);
        return (dest == src1) || (two_src && (dest == src2));
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/write-back/status bundle of the register scoreboard
//
// Purpose: groups the ID-stage issue request, the WB-stage write notification
//          and the scoreboard status outputs.
// Ports:   master drives issue_*, forward_en, flush, wb_*; reads hazard,
//          pending_mask, busy, err. slave is the scoreboard side.
interface reg_scoreboard_if;
    import sb_pkg::*;

    logic                issue_valid;
    reg_idx_t            issue_src1;
    reg_idx_t            issue_src2;
    logic                issue_two_src;
    reg_idx_t            issue_dest;
    logic                issue_wb_en;
    logic                issue_mem_r_en;
    logic                forward_en;
    logic                flush;
    logic                wb_valid;
    reg_idx_t            wb_dest;
    logic                hazard;
    logic [NUM_REGS-1:0] pending_mask;
    logic                busy;
    logic                err;

    modport master (
        output issue_valid, issue_src1, issue_src2, issue_two_src, issue_dest,
               issue_wb_en, issue_mem_r_en, forward_en, flush, wb_valid, wb_dest,
        input  hazard, pending_mask, busy, err
    );

    modport slave (
        input  issue_valid, issue_src1, issue_src2, issue_two_src, issue_dest,
               issue_wb_en, issue_mem_r_en, forward_en, flush, wb_valid, wb_dest,
        output hazard, pending_mask, busy, err
    );

endinterface

// File: rtl/reg_pending_ctr.sv
// rtl/reg_pending_ctr.sv - saturating count of outstanding writes to one register
//
// Purpose: counts issued-but-not-retired writes to a single register.
// Ports:   clk, rst (async, active-high); inc (write issued), dec (write
//          retired); count (current value), zero (count == 0), err (one-cycle
//          pulse on increment at max or decrement at zero).
module reg_pending_ctr
    import sb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output cnt_t count,
    output logic zero,
    output logic err
);

    logic overflow;
    logic underflow;

    // A simultaneous inc and dec cancel, so neither can overflow nor underflow.
    assign overflow  = inc & ~dec & (count == CNT_MAX);
    assign underflow = dec & ~inc & (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc & ~dec & ~overflow) begin
            count <= count + 1'b1;
        end else if (dec & ~inc & ~underflow) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign err  = overflow | underflow;

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register pending-write scoreboard with hazard detection
//
// Purpose: tracks outstanding writes per register and raises a stall request
//          for RAW hazards (no forwarding) or load-use hazards (forwarding).
// Ports:   clk, rst (async, active-high); sb (slave side of reg_scoreboard_if):
//          issue_*, forward_en, flush, wb_valid, wb_dest in; hazard
//          (combinational), pending_mask, busy, err out.
module reg_scoreboard
    import sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  sb
);

    cnt_t                count_v [NUM_REGS];
    logic [NUM_REGS-1:0] zero_v;
    logic [NUM_REGS-1:0] err_v;

    logic     exe_ld_v;
    reg_idx_t exe_ld_dest;
    logic     err_q;

    logic hazard_raw;
    logic hazard_ld;
    logic hazard;
    logic accept;
    logic inc_en;
    logic ld_capture;

    // Counters are read before this cycle's updates, so a same-cycle
    // write-back still stalls for one conservative cycle.
    assign hazard_raw = (count_v[sb.issue_src1] != '0) |
                        (sb.issue_two_src & (count_v[sb.issue_src2] != '0));
    assign hazard_ld  = exe_ld_v &
                        src_match(exe_ld_dest, sb.issue_src1, sb.issue_src2, sb.issue_two_src);
    assign hazard     = sb.issue_valid & (sb.forward_en ? hazard_ld : hazard_raw);

    assign accept     = sb.issue_valid & ~hazard & ~sb.flush;
    assign inc_en     = accept & sb.issue_wb_en;
    assign ld_capture = inc_en & sb.issue_mem_r_en;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_ctr
        reg_pending_ctr u_ctr (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_en & (sb.issue_dest == REG_AW'(r))),
            .dec   (sb.wb_valid & (sb.wb_dest == REG_AW'(r))),
            .count (count_v[r]),
            .zero  (zero_v[r]),
            .err   (err_v[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_ld_v    <= 1'b0;
            exe_ld_dest <= '0;
            err_q       <= 1'b0;
        end else begin
            exe_ld_v    <= ld_capture;
            exe_ld_dest <= ld_capture ? sb.issue_dest : '0;
            if (|err_v) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sb.hazard       = hazard;
    assign sb.pending_mask = ~zero_v;
    assign sb.busy         = ~(&zero_v);
    assign sb.err          = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_scoreboard_if bus ();

    reg_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt [16];
    bit m_err;
    bit m_ld_v;
    int m_ld_dest;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_mask();
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    function automatic bit m_hazard();
        int s1 = int'(bus.issue_src1);
        int s2 = int'(bus.issue_src2);
        if (!bus.issue_valid) return 1'b0;
        if (bus.forward_en)
            return m_ld_v && (m_ld_dest == s1 || (bus.issue_two_src && m_ld_dest == s2));
        return (m_cnt[s1] > 0) || (bus.issue_two_src && m_cnt[s2] > 0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_err = 0;
        m_ld_v = 0;
        m_ld_dest = 0;
    endtask

    task automatic m_step(input bit haz);
        bit acc = bus.issue_valid && !haz && !bus.flush;
        bit inc = acc && bus.issue_wb_en;
        int d   = int'(bus.issue_dest);
        int w   = int'(bus.wb_dest);
        if (!(inc && bus.wb_valid && d == w)) begin
            if (inc) begin
                if (m_cnt[d] == 3) m_err = 1; else m_cnt[d]++;
            end
            if (bus.wb_valid) begin
                if (m_cnt[w] == 0) m_err = 1; else m_cnt[w]--;
            end
        end
        m_ld_v    = inc && bus.issue_mem_r_en;
        m_ld_dest = d;
    endtask

    task automatic drive(input bit v, input int s1, input int s2, input bit two, input int d,
                         input bit wb, input bit ld, input bit fwd, input bit fl,
                         input bit wv, input int wd);
        bus.issue_valid    = v;
        bus.issue_src1     = 4'(s1);
        bus.issue_src2     = 4'(s2);
        bus.issue_two_src  = two;
        bus.issue_dest     = 4'(d);
        bus.issue_wb_en    = wb;
        bus.issue_mem_r_en = ld;
        bus.forward_en     = fwd;
        bus.flush          = fl;
        bus.wb_valid       = wv;
        bus.wb_dest        = 4'(wd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs are set just after a rising edge; outputs are compared at the falling edge.
    task automatic do_cycle();
        bit h;
        @(negedge clk);
        h = m_hazard();
        chk("hazard", {31'd0, bus.hazard}, {31'd0, h});
        chk("pending_mask", {16'd0, bus.pending_mask}, {16'd0, m_mask()});
        chk("busy", {31'd0, bus.busy}, {31'd0, (m_mask() != 0)});
        chk("err", {31'd0, bus.err}, {31'd0, m_err});
        m_step(h);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; results must appear before the next edge.
    task automatic do_reset(input string tag);
        idle();
        rst = 1'b1;
        #1;
        m_reset();
        chk({tag, "_mask"}, {16'd0, bus.pending_mask}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wd;
        idle();
        m_reset();
        #12;
        chk("rst_hazard", {31'd0, bus.hazard}, 32'd0);
        chk("rst_mask", {16'd0, bus.pending_mask}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // RAW stall on R3 until the cycle after its write-back.
        drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        do_cycle();
        drive(1, 3, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        #1 chk("r3_stall", {31'd0, bus.hazard}, 32'd1);
        do_cycle();
        do_cycle();
        drive(1, 3, 0, 0, 6, 1, 0, 0, 0, 1, 3);
        #1 chk("r3_wb_same_cycle", {31'd0, bus.hazard}, 32'd1);
        do_cycle();
        drive(1, 3, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        #1 chk("r3_released", {31'd0, bus.hazard}, 32'd0);
        chk("r3_mask", {16'd0, bus.pending_mask}, 32'd0);
        do_cycle();

        // Load-use with forwarding, then the same shape with a non-load.
        do_reset("fwd_rst");
        drive(1, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0);
        do_cycle();
        drive(1, 0, 5, 1, 8, 1, 0, 1, 0, 0, 0);
        #1 chk("ld_use_stall", {31'd0, bus.hazard}, 32'd1);
        do_cycle();
        #1 chk("ld_use_one_cycle", {31'd0, bus.hazard}, 32'd0);
        do_cycle();
        drive(1, 0, 0, 0, 10, 1, 0, 1, 0, 0, 0);
        do_cycle();
        drive(1, 0, 10, 1, 11, 1, 0, 1, 0, 0, 0);
        #1 chk("alu_no_stall", {31'd0, bus.hazard}, 32'd0);
        do_cycle();

        // Simultaneous increment and decrement on R7.
        do_reset("r7_rst");
        drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        do_cycle();
        drive(1, 0, 0, 0, 7, 1, 0, 0, 0, 1, 7);
        do_cycle();
        chk("r7_mask", {31'd0, bus.pending_mask[7]}, 32'd1);
        chk("r7_no_err", {31'd0, bus.err}, 32'd0);

        // Overflow on R2, then underflow on R9 after a reset.
        do_reset("ovf_rst");
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
            do_cycle();
        end
        chk("r2_ovf_err", {31'd0, bus.err}, 32'd1);
        chk("r2_still_pending", {31'd0, bus.pending_mask[2]}, 32'd1);
        do_reset("udf_rst");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        do_cycle();
        chk("r9_udf_err", {31'd0, bus.err}, 32'd1);

        // Flushed load to R4 neither pends nor arms the load-use check.
        do_reset("flush_rst");
        drive(1, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0);
        do_cycle();
        chk("flush_mask4", {31'd0, bus.pending_mask[4]}, 32'd0);
        drive(1, 4, 0, 0, 5, 1, 0, 1, 0, 0, 0);
        #1 chk("flush_no_ld", {31'd0, bus.hazard}, 32'd0);
        do_cycle();

        // Three registers pending, then reset mid-cycle.
        do_reset("pre3_rst");
        for (int i = 0; i < 3; i++) begin
            drive(1, 15, 15, 0, i + 1, 1, 0, 0, 0, 0, 0);
            do_cycle();
        end
        chk("three_pending", {16'd0, bus.pending_mask}, 32'h000e);
        do_reset("mid_rst");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 800; c++) begin
            if (c % 200 == 199) begin
                do_reset("rand_rst");
            end else begin
                wd = int'($urandom_range(0, 15));
                if ($urandom_range(0, 4) != 0) begin
                    for (int k = 0; k < 16; k++) begin
                        if (m_cnt[(wd + k) % 16] != 0) begin
                            wd = (wd + k) % 16;
                            break;
                        end
                    end
                end
                drive($urandom_range(0, 3) != 0,
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 2) != 0, wd);
                do_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports listed clock and reset first.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 issue_valid  in  1  the ID-stage instruction requests issue this cycle.
REQ-005 issue_src1 / issue_src2  in  4 each  source register numbers of the issuing instruction.
REQ-006 issue_two_src  in  1  issue_src2 is a real operand.
REQ-007 issue_dest  in  4  destination register of the issuing instruction.
REQ-008 issue_wb_en  in  1  the issuing instruction writes issue_dest.
REQ-009 issue_mem_r_en  in  1  the issuing instruction is a load.
REQ-010 forward_en  in  1  forwarding mode: 1 = forwarding present, 0 = none.
REQ-011 flush  in  1  branch-taken kill of the instruction in ID this cycle.
REQ-012 wb_valid  in  1  the WB stage writes the register file this cycle.
REQ-013 wb_dest  in  4  register written by the WB stage.
REQ-014 hazard  out  1  stall request to the IF/ID freeze; combinational.
REQ-015 pending_mask  out  16  bit r = 1 while register r has an outstanding write.
REQ-016 busy  out  1  OR of pending_mask.
REQ-017 err  out  1  sticky counter overflow or underflow flag.

Function
REQ-018 The block SHALL hold a 2-bit pending-write counter per register, 16 counters in total, each saturating at 3.
REQ-019 accept = issue_valid & ~hazard & ~flush; an accepted instruction with issue_wb_en=1 SHALL increment cnt[issue_dest] at the next edge.
REQ-020 wb_valid=1 SHALL decrement cnt[wb_dest] at the next edge.
REQ-021 An increment and a decrement on the same register in one cycle SHALL leave that counter unchanged and SHALL NOT set err.
REQ-022 An increment at 3 or a decrement at 0 SHALL leave the counter unchanged and SHALL set err until reset.
REQ-023 With forward_en=0, hazard SHALL equal (cnt[src1]!=0) | (issue_two_src & cnt[src2]!=0), gated by issue_valid.
REQ-024 With forward_en=1, hazard SHALL be 1 only when issue_valid=1, exe_ld_v=1, and exe_ld_dest equals src1, or equals src2 with issue_two_src=1 (load-use).
REQ-025 exe_ld_v / exe_ld_dest SHALL register (accept & issue_wb_en & issue_mem_r_en) and issue_dest each cycle; they clear when no such accept occurs.
REQ-026 hazard SHALL use pre-update counter values: a same-cycle write-back does not remove a stall, giving one conservative cycle.
REQ-027 flush=1 SHALL suppress the counter increment and the exe_ld capture of the current issue; instructions already issued still retire normally.
REQ-028 pending_mask[r] SHALL be (cnt[r]!=0) and busy SHALL be |pending_mask; both are registered-state derived with zero added latency.

Reset
REQ-029 rst SHALL clear all counters, exe_ld_v, exe_ld_dest and err asynchronously, so that hazard=0, pending_mask=0, busy=0 and err=0.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding pending state; the pipeline is flushed by the same reset.

Structure
REQ-031 Package sb_pkg SHALL hold NUM_REGS=16, REG_AW=4, CNT_W=2 and CNT_MAX=3.
REQ-032 One sub-module, reg_pending_ctr (inc, dec, count, zero, err pulse), SHALL be instantiated 16 times.

Verification
REQ-033 Issue dest=R3, wb_en=1; next cycle issue src1=R3, forward_en=0 -> hazard=1 until the cycle after wb_valid with wb_dest=3, then hazard=0 and pending_mask=0.
REQ-034 forward_en=1, load to R5 accepted; next cycle src2=R5 with two_src=1 -> hazard=1 for exactly one cycle; the same case with a non-load -> hazard=0.
REQ-035 Same cycle: accept dest=R7 and wb_valid with wb_dest=7 while cnt[7]=1 -> cnt[7] stays 1, err=0.
REQ-036 Four accepted writes to R2 with no WB -> cnt[2]=3, err=1 after the 4th; a WB to R9 with cnt[9]=0 -> err=1.
REQ-037 flush=1 with issue dest=R4 -> pending_mask[4]=0 next cycle and exe_ld_v=0.
REQ-038 rst asserted asynchronously with 3 registers pending -> pending_mask=0, busy=0, err=0 before the next clock edge.
